mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mau_pkg.sv | 43 ++++
 rtl/mau_lane.sv | 42 ++++
 rtl/mem_access_unit.sv | 144 ++++++++++++++
 tb/tb_mem_access_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit: access-size encoding,
// FSM state enum, captured request record and the alignment rule.
// Alignment trapping is enabled by defining MAU_MISALIGN_TRAP_EN.
package mau_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DATA  = 3'd3,
        MERGE = 3'd4,
        ERR   = 3'd5
    } mau_state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rmw;
    } mau_req_t;

    // True when the access would straddle its natural boundary, or uses
    // the reserved size code.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mau_lane.sv
// Byte-lane steering between a 32-bit RAM word and a CPU access:
// extracts and extends load data, and merges sub-word store data into
// the word read back for a read-modify-write. Purely combinational.
module mau_lane
    import mau_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [1:0]  byte_off,
    input  logic [31:0] ram_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Select the addressed lane, extend it for loads, replace it for stores.
    // Halfwords only look at byte_off[1]; a stray byte_off[0] is ignored.
    always_comb begin
        lane_b     = ram_word[{byte_off, 3'b000} +: 8];
        lane_h     = ram_word[{byte_off[1], 4'b0000} +: 16];
        load_data  = ram_word;
        merge_data = ram_word;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{sgn & lane_b[7]}}, lane_b};
                merge_data[{byte_off, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data = {{16{sgn & lane_h[15]}}, lane_h};
                merge_data[{byte_off[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                load_data  = ram_word;
                merge_data = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// CPU load/store front end for a synchronous single-port word RAM.
// Word stores write directly; sub-word stores do a read-modify-write.
// Define MAU_MISALIGN_TRAP_EN to reject misaligned and reserved-size
// requests through the ERR state; otherwise low address bits are ignored.
//
// state | meaning
// IDLE  | ready; accept and classify a request
// WRITE | full-word store to RAM, respond
// READ  | present word address, RAM data arrives next cycle
// DATA  | return extracted load data
// MERGE | write ram_q with the store lane(s) replaced, respond
// ERR   | reject request, no RAM access
module mem_access_unit
    import mau_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misalign,
    output logic        ram_wren,
    output logic [29:0] ram_address,
    output logic [31:0] ram_data,
    input  logic [31:0] ram_q
);

    mau_state_t state, next_state;
    mau_req_t   req_q;
    logic       accept;
    logic       req_bad;
    logic       req_sub;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    assign accept  = req_valid && (state == IDLE);
    assign req_sub = (req_size == SZ_BYTE) || (req_size == SZ_HALF);

`ifdef MAU_MISALIGN_TRAP_EN
    assign req_bad = is_misaligned(req_size, req_addr[1:0]);
`else
    assign req_bad = 1'b0;
`endif

    // State register; reset forces IDLE so ram_wren drops asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Capture the request fields on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
        end else if (accept) begin
            req_q.we    <= req_we;
            req_q.size  <= req_size;
            req_q.sgn   <= req_signed;
            req_q.addr  <= req_addr;
            req_q.wdata <= req_wdata;
            req_q.rmw   <= req_we && req_sub;
        end
    end

    mau_lane u_lane (
        .size       (req_q.size),
        .sgn        (req_q.sgn),
        .byte_off   (req_q.addr[1:0]),
        .ram_word   (ram_q),
        .wdata      (req_q.wdata),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // Next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_bad) begin
                        next_state = ERR;
                    end else if (req_we && !req_sub) begin
                        next_state = WRITE;
                    end else begin
                        next_state = READ;
                    end
                end
            end
            READ:    next_state = req_q.rmw ? MERGE : DATA;
            WRITE,
            DATA,
            MERGE,
            ERR:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode; everything is a function of state and captured fields.
    always_comb begin
        req_ready     = (state == IDLE);
        resp_valid    = 1'b0;
        resp_rdata    = '0;
        resp_misalign = 1'b0;
        ram_wren      = 1'b0;
        ram_address   = req_q.addr[31:2];
        ram_data      = '0;
        case (state)
            WRITE: begin
                ram_wren   = 1'b1;
                ram_data   = req_q.wdata;
                resp_valid = 1'b1;
            end
            DATA: begin
                resp_valid = 1'b1;
                resp_rdata = load_data;
            end
            MERGE: begin
                ram_wren   = 1'b1;
                ram_data   = merge_data;
                resp_valid = 1'b1;
            end
            ERR: begin
                resp_valid = 1'b1;
`ifdef MAU_MISALIGN_TRAP_EN
                resp_misalign = 1'b1;
`endif
            end
            default: begin
                resp_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed, table-driven bench for mem_access_unit with a behavioural
// synchronous word RAM. Expectations follow MAU_MISALIGN_TRAP_EN if defined.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misalign;
    logic        ram_wren;
    logic [29:0] ram_address;
    logic [31:0] ram_data;
    logic [31:0] ram_q;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [0:63];
    logic        pre_en = 1'b0;
    logic [5:0]  pre_idx = '0;
    logic [31:0] pre_val = '0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_size      (req_size),
        .req_signed    (req_signed),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_misalign (resp_misalign),
        .ram_wren      (ram_wren),
        .ram_address   (ram_address),
        .ram_data      (ram_data),
        .ram_q         (ram_q)
    );

    // Synchronous RAM with one-cycle read latency and a bench preload port.
    always @(posedge clk) begin
        if (pre_en) mem[pre_idx] <= pre_val;
        else if (ram_wren) mem[ram_address[5:0]] <= ram_data;
        ram_q <= mem[ram_address[5:0]];
    end

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%h want=%h", name, idx, act, exp);
        end
    endtask

    // Outputs that must idle at zero whenever no response is being given.
    always @(negedge clk) begin
        if (rst_n && !resp_valid) begin
            chk("idle_rdata", 0, resp_rdata, 32'h0);
            chk("idle_misalign", 0, {31'h0, resp_misalign}, 32'h0);
            chk("idle_wren", 0, {31'h0, ram_wren}, 32'h0);
        end
    end

    typedef struct {
        bit          do_pre;
        logic [5:0]  pre_idx;
        logic [31:0] pre_val;
        bit          we;
        logic [1:0]  size;
        bit          sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_mis;
        int          exp_lat;
        bit          exp_wr;
        logic [29:0] exp_waddr;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit do_pre, logic [5:0] pidx, logic [31:0] pval,
                                bit we, logic [1:0] size, bit sgn,
                                logic [31:0] addr, logic [31:0] wdata,
                                logic [31:0] exp_rdata, bit exp_mis, int exp_lat,
                                bit exp_wr, logic [29:0] exp_waddr,
                                logic [31:0] exp_wdata);
        vec_t v;
        v.do_pre = do_pre; v.pre_idx = pidx; v.pre_val = pval;
        v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_mis = exp_mis; v.exp_lat = exp_lat;
        v.exp_wr = exp_wr; v.exp_waddr = exp_waddr; v.exp_wdata = exp_wdata;
        return v;
    endfunction

    task automatic preset(input logic [5:0] idx, input logic [31:0] val);
        @(negedge clk);
        pre_en = 1'b1; pre_idx = idx; pre_val = val;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    task automatic apply(input vec_t v, input int idx);
        int          cyc;
        bit          got;
        bit          wr_seen;
        logic [31:0] rd;
        logic        mis;
        logic [31:0] wr_d;
        logic [29:0] wr_a;
        cyc = 0; got = 0; wr_seen = 0; rd = '0; mis = 1'b0; wr_d = '0; wr_a = '0;
        if (v.do_pre) preset(v.pre_idx, v.pre_val);
        @(negedge clk);
        chk("ready_idle", idx, {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_we = v.we; req_size = v.size; req_signed = v.sgn;
        req_addr = v.addr; req_wdata = v.wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        while (!got && cyc < 8) begin
            @(negedge clk);
            cyc++;
            chk("ready_busy", idx, {31'h0, req_ready}, 32'h0);
            if (ram_wren) begin
                wr_seen = 1; wr_d = ram_data; wr_a = ram_address;
            end
            if (resp_valid) begin
                got = 1; rd = resp_rdata; mis = resp_misalign;
            end
        end
        chk("resp_seen", idx, {31'h0, got}, 32'h1);
        chk("latency", idx, cyc, v.exp_lat);
        chk("rdata", idx, rd, v.exp_rdata);
        chk("misalign", idx, {31'h0, mis}, {31'h0, v.exp_mis});
        chk("wren_seen", idx, {31'h0, wr_seen}, {31'h0, v.exp_wr});
        if (v.exp_wr) begin
            chk("wr_addr", idx, {2'b00, wr_a}, {2'b00, v.exp_waddr});
            chk("wr_data", idx, wr_d, v.exp_wdata);
        end
    endtask

    initial begin
        // Load vectors
        vecs.push_back(mk(1, 6'd4, 32'h11223344, 0, 2'd0, 1, 32'h13, 32'h0, 32'h00000011, 0, 2, 0, 30'd0, 32'h0));
        vecs.push_back(mk(0, 6'd0, 32'h0,        0, 2'd0, 1, 32'h10, 32'h0, 32'h00000044, 0, 2, 0, 30'd0, 32'h0));
        vecs.push_back(mk(0, 6'd0, 32'h0,        0, 2'd1, 0, 32'h10, 32'h0, 32'h00003344, 0, 2, 0, 30'd0, 32'h0));
        vecs.push_back(mk(0, 6'd0, 32'h0,        0, 2'd2, 1, 32'h10, 32'h0, 32'h11223344, 0, 2, 0, 30'd0, 32'h0));
        vecs.push_back(mk(1, 6'd4, 32'h80FF0000, 0, 2'd1, 1, 32'h12, 32'h0, 32'hFFFF80FF, 0, 2, 0, 30'd0, 32'h0));
        vecs.push_back(mk(0, 6'd0, 32'h0,        0, 2'd1, 0, 32'h12, 32'h0, 32'h000080FF, 0, 2, 0, 30'd0, 32'h0));
        vecs.push_back(mk(0, 6'd0, 32'h0,        0, 2'd0, 1, 32'h12, 32'h0, 32'hFFFFFFFF, 0, 2, 0, 30'd0, 32'h0));
        vecs.push_back(mk(0, 6'd0, 32'h0,        0, 2'd0, 0, 32'h13, 32'h0, 32'h00000080, 0, 2, 0, 30'd0, 32'h0));
        // Stores and read-back
        vecs.push_back(mk(1, 6'd2, 32'hAABBCCDD, 1, 2'd0, 0, 32'h09, 32'h0000005A, 32'h0, 0, 2, 1, 30'd2, 32'hAABB5ADD));
        vecs.push_back(mk(0, 6'd0, 32'h0,        0, 2'd2, 0, 32'h08, 32'h0, 32'hAABB5ADD, 0, 2, 0, 30'd0, 32'h0));
        vecs.push_back(mk(0, 6'd0, 32'h0,        1, 2'd1, 0, 32'h0A, 32'hFFFF1234, 32'h0, 0, 2, 1, 30'd2, 32'h12345ADD));
        vecs.push_back(mk(0, 6'd0, 32'h0,        0, 2'd1, 1, 32'h0A, 32'h0, 32'h00001234, 0, 2, 0, 30'd0, 32'h0));
        vecs.push_back(mk(0, 6'd0, 32'h0,        1, 2'd2, 0, 32'h20, 32'hDEADBEEF, 32'h0, 0, 1, 1, 30'd8, 32'hDEADBEEF));
        vecs.push_back(mk(0, 6'd0, 32'h0,        0, 2'd2, 0, 32'h20, 32'h0, 32'hDEADBEEF, 0, 2, 0, 30'd0, 32'h0));
        vecs.push_back(mk(0, 6'd0, 32'h0,        1, 2'd0, 0, 32'h23, 32'h000000A5, 32'h0, 0, 2, 1, 30'd8, 32'hA5ADBEEF));
        vecs.push_back(mk(0, 6'd0, 32'h0,        0, 2'd0, 1, 32'h23, 32'h0, 32'hFFFFFFA5, 0, 2, 0, 30'd0, 32'h0));
        // Alignment corner cases
`ifdef MAU_MISALIGN_TRAP_EN
        vecs.push_back(mk(0, 6'd0, 32'h0,        1, 2'd2, 0, 32'h22, 32'hCAFEF00D, 32'h0, 1, 1, 0, 30'd0, 32'h0));
        vecs.push_back(mk(0, 6'd0, 32'h0,        0, 2'd2, 0, 32'h20, 32'h0, 32'hA5ADBEEF, 0, 2, 0, 30'd0, 32'h0));
        vecs.push_back(mk(0, 6'd0, 32'h0,        0, 2'd3, 0, 32'h20, 32'h0, 32'h0, 1, 1, 0, 30'd0, 32'h0));
        vecs.push_back(mk(0, 6'd0, 32'h0,        0, 2'd1, 0, 32'h21, 32'h0, 32'h0, 1, 1, 0, 30'd0, 32'h0));
`else
        vecs.push_back(mk(0, 6'd0, 32'h0,        1, 2'd2, 0, 32'h22, 32'hCAFEF00D, 32'h0, 0, 1, 1, 30'd8, 32'hCAFEF00D));
        vecs.push_back(mk(0, 6'd0, 32'h0,        0, 2'd2, 0, 32'h20, 32'h0, 32'hCAFEF00D, 0, 2, 0, 30'd0, 32'h0));
        vecs.push_back(mk(0, 6'd0, 32'h0,        0, 2'd3, 0, 32'h20, 32'h0, 32'hCAFEF00D, 0, 2, 0, 30'd0, 32'h0));
        vecs.push_back(mk(0, 6'd0, 32'h0,        0, 2'd1, 0, 32'h21, 32'h0, 32'h0000F00D, 0, 2, 0, 30'd0, 32'h0));
`endif

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_ready", 0, {31'h0, req_ready}, 32'h1);
        chk("rst_resp_valid", 0, {31'h0, resp_valid}, 32'h0);
        chk("rst_rdata", 0, resp_rdata, 32'h0);
        chk("rst_misalign", 0, {31'h0, resp_misalign}, 32'h0);
        chk("rst_wren", 0, {31'h0, ram_wren}, 32'h0);
        chk("rst_address", 0, {2'b00, ram_address}, 32'h0);
        chk("rst_data", 0, ram_data, 32'h0);
        rst_n = 1'b1;

        foreach (vecs[i]) apply(vecs[i], i);

        // Reset during MERGE: write must be abandoned immediately
        preset(6'd2, 32'hAABBCCDD);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h08; req_wdata = 32'h77;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("merge_rd_wren", 100, {31'h0, ram_wren}, 32'h0);
        @(negedge clk);
        chk("merge_wren", 100, {31'h0, ram_wren}, 32'h1);
        chk("merge_data", 100, ram_data, 32'hAABBCC77);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_wren", 100, {31'h0, ram_wren}, 32'h0);
        chk("arst_resp", 100, {31'h0, resp_valid}, 32'h0);
        chk("arst_ready", 100, {31'h0, req_ready}, 32'h1);
        chk("arst_data", 100, ram_data, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 100, {31'h0, req_ready}, 32'h1);
        chk("post_rst_mem", 100, mem[2], 32'hAABBCCDD);
        apply(mk(0, 6'd0, 32'h0, 0, 2'd2, 0, 32'h08, 32'h0, 32'hAABBCCDD, 0, 2, 0, 30'd0, 32'h0), 101);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
